// File: rtl/tinyqv_pkg.sv
// Shared definitions for the tinyQV data-port arbiter: request encodings,
// arbiter state and owner types, and the request-detect helper.
package tinyqv_pkg;

    localparam logic [1:0] REQ_IDLE  = 2'b11;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // A read and a write raised together is still a request; both are forwarded.
    function automatic logic is_req(input logic [1:0] read_n, input logic [1:0] write_n);
        return (read_n != REQ_IDLE) || (write_n != REQ_IDLE);
    endfunction

endpackage

// File: rtl/tinyqv_data_arbiter_if.sv
// Bundle of both requester data ports and the shared memory-controller port.
// slave: the arbiter's view; master: the requesters plus memory controller.
interface tinyqv_data_arbiter_if #(
    parameter int unsigned ADDR_W = 28
) ();

    logic [ADDR_W-1:0] a_addr;
    logic [1:0]        a_write_n;
    logic [1:0]        a_read_n;
    logic [31:0]       a_data_out;
    logic              a_ready;
    logic [31:0]       a_data_in;

    logic [ADDR_W-1:0] b_addr;
    logic [1:0]        b_write_n;
    logic [1:0]        b_read_n;
    logic [31:0]       b_data_out;
    logic              b_ready;
    logic [31:0]       b_data_in;

    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_write_n;
    logic [1:0]        mem_read_n;
    logic [31:0]       mem_data_to_write;
    logic              mem_data_ready;
    logic [31:0]       mem_data_from_read;

    modport slave (
        input  a_addr, a_write_n, a_read_n, a_data_out,
        output a_ready, a_data_in,
        input  b_addr, b_write_n, b_read_n, b_data_out,
        output b_ready, b_data_in,
        output mem_addr, mem_write_n, mem_read_n, mem_data_to_write,
        input  mem_data_ready, mem_data_from_read
    );

    modport master (
        output a_addr, a_write_n, a_read_n, a_data_out,
        input  a_ready, a_data_in,
        output b_addr, b_write_n, b_read_n, b_data_out,
        input  b_ready, b_data_in,
        input  mem_addr, mem_write_n, mem_read_n, mem_data_to_write,
        output mem_data_ready, mem_data_from_read
    );

endinterface

// File: rtl/tinyqv_data_arbiter.sv
// Round-robin arbiter sharing the tinyQV memory-controller data port between
// requester A (CPU) and requester B; grants whole transactions.
module tinyqv_data_arbiter
    import tinyqv_pkg::*;
#(
    parameter int unsigned ADDR_W = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    tinyqv_data_arbiter_if.slave bus
);

    typedef logic [ADDR_W-1:0] addr_t;

    arb_state_e  state_q, state_d;
    owner_e      last_q, last_d;
    logic        a_req, b_req;

    addr_t       sel_addr;
    logic [1:0]  sel_read_n;
    logic [1:0]  sel_write_n;
    logic [31:0] sel_wdata;

    always_comb begin
        a_req = is_req(bus.a_read_n, bus.a_write_n);
        b_req = is_req(bus.b_read_n, bus.b_write_n);
    end

    // Completion takes priority over a same-cycle drop; only a completion updates last.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (a_req && (!b_req || last_q == OWN_B)) begin
                    state_d = GNT_A;
                end else if (b_req) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (bus.mem_data_ready) begin
                    state_d = IDLE;
                    last_d  = OWN_A;
                end else if (!a_req) begin
                    state_d = IDLE;
                end
            end
            GNT_B: begin
                if (bus.mem_data_ready) begin
                    state_d = IDLE;
                    last_d  = OWN_B;
                end else if (!b_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= OWN_B;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        sel_addr    = '0;
        sel_read_n  = REQ_IDLE;
        sel_write_n = REQ_IDLE;
        sel_wdata   = '0;
        unique case (state_q)
            GNT_A: begin
                sel_addr    = bus.a_addr;
                sel_read_n  = bus.a_read_n;
                sel_write_n = bus.a_write_n;
                sel_wdata   = bus.a_data_out;
            end
            GNT_B: begin
                sel_addr    = bus.b_addr;
                sel_read_n  = bus.b_read_n;
                sel_write_n = bus.b_write_n;
                sel_wdata   = bus.b_data_out;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr          = sel_addr;
    assign bus.mem_read_n        = sel_read_n;
    assign bus.mem_write_n       = sel_write_n;
    assign bus.mem_data_to_write = sel_wdata;

    // Ready is gated by the grant so a completion seen while idle is discarded.
    assign bus.a_ready   = bus.mem_data_ready && (state_q == GNT_A);
    assign bus.b_ready   = bus.mem_data_ready && (state_q == GNT_B);
    assign bus.a_data_in = bus.mem_data_from_read;
    assign bus.b_data_in = bus.mem_data_from_read;

endmodule

// File: doc/tinyqv_data_arbiter.md
# tinyqv_data_arbiter

Two-requester arbiter that shares the single data port of the tinyQV memory controller between the CPU data port (requester A) and a secondary bus master (requester B, e.g. a DMA or debug loader). Sits between `tinyqv_cpu`/secondary master and `tinyqv_mem_ctrl`, re-presenting the same data-port protocol on each side. Grants whole transactions with round-robin fairness and routes `data_ready`/`data_from_read` back to the granted requester only.

## Interface
Parameters:
- `ADDR_W`, 28: data address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `a_addr`  in  ADDR_W  requester A address.
- `a_write_n`, `a_read_n`  in  2 each  requester A write/read request; 2'b11 idle, 00 byte, 01 half, 10 word.
- `a_data_out`  in  32  requester A write data.
- `a_ready`  out  1  transaction-complete pulse to A.
- `a_data_in`  out  32  read data to A.
- `b_addr`, `b_write_n`, `b_read_n`, `b_data_out`, `b_ready`, `b_data_in`: same as A, for requester B.
- `mem_addr`  out  ADDR_W  to memory controller.
- `mem_write_n`, `mem_read_n`  out  2 each  to memory controller.
- `mem_data_to_write`  out  32  to memory controller.
- `mem_data_ready`  in  1  completion pulse from memory controller.
- `mem_data_from_read`  in  32  read data from memory controller.

## Operation
- Requester X is requesting when `x_read_n != 2'b11` or `x_write_n != 2'b11`. Both non-idle at once is a protocol violation and is treated as a request; both fields are forwarded unchanged.
- States: IDLE, GNT_A, GNT_B. Register `last` records the most recently granted requester.
- IDLE: only A requesting -> GNT_A; only B -> GNT_B; both -> the one not equal to `last`; neither -> stay.
- GNT_X: mem outputs are a combinational mux of requester X's inputs. Stay until `mem_data_ready`; then `last <= X`, next state IDLE.
- GNT_X and X drops its request before `mem_data_ready` (abort): next state IDLE, `last` unchanged; mem outputs already show 11 that cycle by the mux.
- IDLE: `mem_read_n = mem_write_n = 2'b11`, `mem_addr` and `mem_data_to_write` = 0.
- `x_ready = mem_data_ready & (state == GNT_X)`; a ready arriving in IDLE is dropped.
- `a_data_in` and `b_data_in` both driven from `mem_data_from_read` unconditionally; only meaningful with the matching ready.
- Requester B is never starved: with both requesting continuously, grants strictly alternate A, B, A, B.

## Timing
- Reset (async assert, sync release): state IDLE, `last` = B (A wins first tie), all mem requests 2'b11, `mem_addr`/`mem_data_to_write` 0, `a_ready`/`b_ready` 0.
- Arbitration latency: request first visible in cycle N (state IDLE) -> mem request visible in cycle N+1.
- Ready path is combinational: `mem_data_ready` in cycle M -> `x_ready` in cycle M. Mem request returns to 11 in cycle M+1.
- Back-to-back: exactly one IDLE cycle between consecutive grants (M+1), so the memory controller always sees at least one idle cycle between transactions.
- Requester must hold address, size and data stable from request until its ready, and must drop its request in the cycle after ready or it is re-arbitrated as a new transaction.
- Reset mid-transaction: outputs go to reset values immediately; in-flight ready is lost.

## Structure
- Shared package `tinyqv_pkg`: `REQ_IDLE = 2'b11`, size encodings (BYTE 00, HALF 01, WORD 10), state enum {IDLE, GNT_A, GNT_B}.
- Single flat module; no sub-module. The 2-input grant mux is inline.

## Test plan
- Reset: `rst` high mid-GNT_A -> mem read/write = 11, addr 0, readies 0 in the same cycle.
- A alone: word read of 0x0000100 at N -> `mem_read_n` = 10, `mem_addr` = 0x0000100 at N+1; `mem_data_ready` with 0xDEADBEEF at N+4 -> `a_ready` = 1, `a_data_in` = 0xDEADBEEF at N+4, `b_ready` = 0, mem request 11 at N+5.
- Tie out of reset: A byte write 0x55 to 0x10, B half read from 0x20 both at N -> A granted first (`mem_write_n` = 00, data 0x55); after A's ready, one idle cycle, then B granted (`mem_read_n` = 01, addr 0x20).
- Continuous contention: both requesting for 6 transactions -> grant order A, B, A, B, A, B; each grant followed by one idle cycle.
- Abort: B granted, B drops to 11 before ready -> IDLE next cycle, `last` unchanged; a late `mem_data_ready` in IDLE produces no `a_ready`/`b_ready`.
- Ready while idle: `mem_data_ready` pulse with no grant -> both readies stay 0, state stays IDLE.
